// File: rtl/cg_pkg.sv
// rtl/cg_pkg.sv - shared state type and default parameters for the clock gate controller
package cg_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SLEEP_REQ = 2'd1,
    GATED     = 2'd2,
    WAKE      = 2'd3
  } cg_state_t;

  localparam int CG_IDLE_CYCLES = 16;
  localparam int CG_WAKE_CYCLES = 2;
  localparam int CG_STAT_W      = 32;

endpackage

// File: rtl/cg_sat_counter.sv
// rtl/cg_sat_counter.sv - saturating up-counter with synchronous clear priority
module cg_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - idle-detecting clock gate enable controller; optional CLOCK_GATE_STATS_EN adds a gated-cycle counter
module clock_gate_ctrl
  import cg_pkg::*;
#(
`ifdef CLOCK_GATE_STATS_EN
  parameter int STAT_W      = CG_STAT_W,
`endif
  parameter int IDLE_CYCLES = CG_IDLE_CYCLES,
  parameter int WAKE_CYCLES = CG_WAKE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              force_on,
  input  logic              sleep_ack,
`ifdef CLOCK_GATE_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] gated_cycles,
`endif
  output logic              gate_en,
  output logic              sleep_req,
  output logic              ready,
  output logic              gated
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  cg_state_t   state_q, state_d;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;
  logic        idle_clr, idle_inc, wake_clr, wake_inc;
  logic        wake, active;

  assign wake   = wake_req | force_on;
  assign active = busy | wake;

  // Counters idle at zero unless their state explicitly lets them count.
  always_comb begin
    state_d  = state_q;
    idle_clr = 1'b1;
    idle_inc = 1'b0;
    wake_clr = 1'b1;
    wake_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (!active) begin
          if (idle_cnt == IDLE_LAST) begin
            state_d = SLEEP_REQ;
          end else begin
            idle_clr = 1'b0;
            idle_inc = 1'b1;
          end
        end
      end
      SLEEP_REQ: begin
        if (active)         state_d = RUN;
        else if (sleep_ack) state_d = GATED;
      end
      GATED: begin
        if (wake) state_d = WAKE;
      end
      WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          state_d = RUN;
        end else begin
          wake_clr = 1'b0;
          wake_inc = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  cg_sat_counter #(.W(IW)) u_idle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (idle_clr),
    .inc   (idle_inc),
    .count (idle_cnt)
  );

  cg_sat_counter #(.W(WW)) u_wake_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wake_clr),
    .inc   (wake_inc),
    .count (wake_cnt)
  );

  // Outputs decode the next state so they land on the same edge as the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      gate_en   <= 1'b1;
      sleep_req <= 1'b0;
      ready     <= 1'b1;
      gated     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_en   <= (state_d != GATED);
      sleep_req <= (state_d == SLEEP_REQ);
      ready     <= (state_d == RUN);
      gated     <= (state_d == GATED);
    end
  end

`ifdef CLOCK_GATE_STATS_EN
  cg_sat_counter #(.W(STAT_W)) u_stat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stats_clr),
    .inc   (~gate_en),
    .count (gated_cycles)
  );
`else
  // No statistics counter in this build.
`endif

endmodule
